// File: rtl/output_p4_arbiter.sv
// Four-input AXI-Stream packet arbiter, round-robin by default.
// Define OUTPUT_P4_ARBITER_STRICT_PRIO_EN for fixed priority (input 0 highest).
`timescale 1ns/1ps
module output_p4_arbiter #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128
) (
    input  logic                            axis_aclk,
    input  logic                            axis_resetn,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_0_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_0_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_0_tuser,
    input  logic                            s_axis_0_tvalid,
    input  logic                            s_axis_0_tlast,
    output logic                            s_axis_0_tready,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_1_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_1_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_1_tuser,
    input  logic                            s_axis_1_tvalid,
    input  logic                            s_axis_1_tlast,
    output logic                            s_axis_1_tready,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_2_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_2_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_2_tuser,
    input  logic                            s_axis_2_tvalid,
    input  logic                            s_axis_2_tlast,
    output logic                            s_axis_2_tready,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_3_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_3_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_3_tuser,
    input  logic                            s_axis_3_tvalid,
    input  logic                            s_axis_3_tlast,
    output logic                            s_axis_3_tready,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    output logic [3:0]                      arb_grant
);

    localparam int KW = C_AXIS_DATA_WIDTH / 8;

    typedef enum logic {IDLE, XFER} state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [3:0]                     r_grant;
    logic [3:0]                     w_grant_nxt;
    logic [1:0]                     r_last;
    logic [1:0]                     w_last_nxt;
    logic [1:0]                     w_idx;
    logic [3:0]                     w_req;
    logic [3:0]                     w_pick;
    logic [3:0]                     w_tlast;
    logic [3:0]                     w_tready;
    logic                           w_done;
    logic [C_AXIS_DATA_WIDTH-1:0]   w_tdata [4];
    logic [KW-1:0]                  w_tkeep [4];
    logic [C_AXIS_TUSER_WIDTH-1:0]  w_tuser [4];

    assign w_req   = {s_axis_3_tvalid, s_axis_2_tvalid,
                      s_axis_1_tvalid, s_axis_0_tvalid};
    assign w_tlast = {s_axis_3_tlast, s_axis_2_tlast,
                      s_axis_1_tlast, s_axis_0_tlast};

    assign w_tdata[0] = s_axis_0_tdata;
    assign w_tdata[1] = s_axis_1_tdata;
    assign w_tdata[2] = s_axis_2_tdata;
    assign w_tdata[3] = s_axis_3_tdata;
    assign w_tkeep[0] = s_axis_0_tkeep;
    assign w_tkeep[1] = s_axis_1_tkeep;
    assign w_tkeep[2] = s_axis_2_tkeep;
    assign w_tkeep[3] = s_axis_3_tkeep;
    assign w_tuser[0] = s_axis_0_tuser;
    assign w_tuser[1] = s_axis_1_tuser;
    assign w_tuser[2] = s_axis_2_tuser;
    assign w_tuser[3] = s_axis_3_tuser;

    assign s_axis_0_tready = w_tready[0];
    assign s_axis_1_tready = w_tready[1];
    assign s_axis_2_tready = w_tready[2];
    assign s_axis_3_tready = w_tready[3];
    assign arb_grant       = r_grant;

    always_comb begin
        w_idx = 2'd0;
        unique case (1'b1)
            r_grant[1]: w_idx = 2'd1;
            r_grant[2]: w_idx = 2'd2;
            r_grant[3]: w_idx = 2'd3;
            default:    w_idx = 2'd0;
        endcase
    end

`ifdef OUTPUT_P4_ARBITER_STRICT_PRIO_EN
    always_comb begin
        w_pick = 4'b0000;
        if (w_req[0])      w_pick = 4'b0001;
        else if (w_req[1]) w_pick = 4'b0010;
        else if (w_req[2]) w_pick = 4'b0100;
        else if (w_req[3]) w_pick = 4'b1000;
    end
`else
    // Scan last+1, last+2, last+3, last; 2-bit sum wraps 3->0.
    always_comb begin
        logic [1:0] v_c;
        logic       v_f;
        w_pick = 4'b0000;
        v_f    = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            v_c = r_last + 2'(i);
            if (!v_f && w_req[v_c]) begin
                w_pick[v_c] = 1'b1;
                v_f         = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        w_tready      = 4'b0000;
        w_done        = 1'b0;
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_last_nxt    = r_last;
        unique case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                m_axis_tdata  = w_tdata[w_idx];
                m_axis_tkeep  = w_tkeep[w_idx];
                m_axis_tuser  = w_tuser[w_idx];
                m_axis_tvalid = w_req[w_idx];
                m_axis_tlast  = w_tlast[w_idx];
                w_tready      = r_grant & {4{m_axis_tready}};
                w_done        = w_req[w_idx] & m_axis_tready
                              & w_tlast[w_idx];
                if (w_done) begin
                    w_grant_nxt = 4'b0000;
                    w_last_nxt  = w_idx;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            r_state <= IDLE;
            r_grant <= 4'b0000;
            r_last  <= 2'd3;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_last  <= w_last_nxt;
        end
    end

endmodule

// File: tb/tb_output_p4_arbiter.sv
// Directed testbench for output_p4_arbiter.
// Sources are small beat tables; merged beats are logged and compared.
`timescale 1ns/1ps
module tb_output_p4_arbiter;

    logic        clk;
    logic        resetn;
    logic [31:0] s_tdata [4];
    logic [3:0]  s_tkeep [4];
    logic [15:0] s_tuser [4];
    logic [3:0]  s_tvalid;
    logic [3:0]  s_tlast;
    wire  [3:0]  s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic [15:0] m_tuser;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic [3:0]  m_grant;

    output_p4_arbiter #(
        .C_AXIS_DATA_WIDTH (32),
        .C_AXIS_TUSER_WIDTH(16)
    ) dut (
        .axis_aclk      (clk),
        .axis_resetn    (resetn),
        .s_axis_0_tdata (s_tdata[0]),
        .s_axis_0_tkeep (s_tkeep[0]),
        .s_axis_0_tuser (s_tuser[0]),
        .s_axis_0_tvalid(s_tvalid[0]),
        .s_axis_0_tlast (s_tlast[0]),
        .s_axis_0_tready(s_tready[0]),
        .s_axis_1_tdata (s_tdata[1]),
        .s_axis_1_tkeep (s_tkeep[1]),
        .s_axis_1_tuser (s_tuser[1]),
        .s_axis_1_tvalid(s_tvalid[1]),
        .s_axis_1_tlast (s_tlast[1]),
        .s_axis_1_tready(s_tready[1]),
        .s_axis_2_tdata (s_tdata[2]),
        .s_axis_2_tkeep (s_tkeep[2]),
        .s_axis_2_tuser (s_tuser[2]),
        .s_axis_2_tvalid(s_tvalid[2]),
        .s_axis_2_tlast (s_tlast[2]),
        .s_axis_2_tready(s_tready[2]),
        .s_axis_3_tdata (s_tdata[3]),
        .s_axis_3_tkeep (s_tkeep[3]),
        .s_axis_3_tuser (s_tuser[3]),
        .s_axis_3_tvalid(s_tvalid[3]),
        .s_axis_3_tlast (s_tlast[3]),
        .s_axis_3_tready(s_tready[3]),
        .m_axis_tdata   (m_tdata),
        .m_axis_tkeep   (m_tkeep),
        .m_axis_tuser   (m_tuser),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tlast   (m_tlast),
        .m_axis_tready  (m_tready),
        .arb_grant      (m_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hot_err = 0;

    logic [32:0] mem [4][16];
    int          hd [4];
    int          tl [4];
    logic [3:0]  stall;
    logic [3:0]  hs;

    logic [31:0] log_d [64];
    logic [15:0] log_u [64];
    logic        log_l [64];
    logic [3:0]  log_g [64];
    int          log_c [64];
    int          log_n;

    logic        snap_mv;
    logic [3:0]  snap_g;
    logic [3:0]  snap_sr;
    logic [31:0] snap_md;

    task automatic push(input int n, input logic [31:0] d,
                        input logic l);
        mem[n][tl[n]] = {l, d};
        tl[n]++;
    endtask

    task automatic drive();
        for (int n = 0; n < 4; n++) begin
            if (hd[n] < tl[n]) begin
                s_tvalid[n] = !stall[n];
                s_tdata[n]  = mem[n][hd[n]][31:0];
                s_tlast[n]  = mem[n][hd[n]][32];
                s_tuser[n]  = ~mem[n][hd[n]][15:0];
                s_tkeep[n]  = 4'hF;
            end else begin
                s_tvalid[n] = 1'b0;
                s_tdata[n]  = 32'h0;
                s_tlast[n]  = 1'b0;
                s_tuser[n]  = 16'h0;
                s_tkeep[n]  = 4'h0;
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        if ($countones(m_grant) > 1) hot_err++;
        hs      = s_tvalid & s_tready;
        snap_mv = m_tvalid;
        snap_g  = m_grant;
        snap_sr = s_tready;
        snap_md = m_tdata;
        if (m_tvalid && m_tready && log_n < 64) begin
            log_d[log_n] = m_tdata;
            log_u[log_n] = m_tuser;
            log_l[log_n] = m_tlast;
            log_g[log_n] = m_grant;
            log_c[log_n] = cyc;
            log_n++;
        end
        @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++)
            if (hs[n]) hd[n]++;
        cyc++;
        drive();
    endtask

    task automatic run_until(input int want, input int budget);
        int b;
        b = budget;
        while (log_n < want && b > 0) begin
            step();
            b--;
        end
        total++;
        if (log_n < want) begin
            bad++;
            $display("FAIL timeout beats got=%0d want=%0d",
                     log_n, want);
        end
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        m_tready = 1'b1;
        stall    = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            hd[n] = 0;
            tl[n] = 0;
        end
        log_n   = 0;
        hot_err = 0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        cyc = 0;
    endtask

    task automatic test_reset();
        resetn   = 1'b0;
        m_tready = 1'b1;
        stall    = 4'b0000;
        for (int n = 0; n < 4; n++) begin
            hd[n] = 0;
            tl[n] = 0;
            push(n, 32'h55, 1'b1);
        end
        drive();
        @(posedge clk);
        #2;
        total++;
        if (m_grant !== 4'b0000) begin
            bad++;
            $display("FAIL rst_grant got=%b exp=0000", m_grant);
        end
        total++;
        if (m_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL rst_tvalid got=%b exp=0", m_tvalid);
        end
        total++;
        if (s_tready !== 4'b0000) begin
            bad++;
            $display("FAIL rst_tready got=%b exp=0000", s_tready);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        push(1, 32'hA1, 1'b0);
        push(1, 32'hA2, 1'b0);
        push(1, 32'hA3, 1'b1);
        drive();
        step();
        total++;
        if (snap_mv !== 1'b0 || snap_sr !== 4'b0000 ||
            snap_md !== 32'h0 || snap_g !== 4'b0000) begin
            bad++;
            $display("FAIL single_idle got v=%b r=%b d=%h g=%b exp 0",
                     snap_mv, snap_sr, snap_md, snap_g);
        end
        step();
        total++;
        if (snap_g !== 4'b0010 || snap_sr !== 4'b0010) begin
            bad++;
            $display("FAIL single_grant got g=%b r=%b exp 0010",
                     snap_g, snap_sr);
        end
        run_until(3, 10);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (log_d[i] !== 32'hA1 + 32'(i) ||
                log_l[i] !== (i == 2) ||
                log_u[i] !== ~(16'hA1 + 16'(i))) begin
                bad++;
                $display("FAIL single_beat%0d got d=%h l=%b u=%h",
                         i, log_d[i], log_l[i], log_u[i]);
            end
        end
        total++;
        if (log_c[0] !== 1 || log_c[2] !== 3) begin
            bad++;
            $display("FAIL single_latency got c0=%0d c2=%0d exp 1 3",
                     log_c[0], log_c[2]);
        end
        step();
        total++;
        if (snap_g !== 4'b0000 || snap_mv !== 1'b0) begin
            bad++;
            $display("FAIL single_return got g=%b v=%b exp 0000 0",
                     snap_g, snap_mv);
        end
    endtask

    task automatic test_all_req();
        int ord [5];
        int pk  [5];
        logic [31:0] e;
`ifdef OUTPUT_P4_ARBITER_STRICT_PRIO_EN
        ord = '{0, 0, 1, 2, 3};
        pk  = '{0, 1, 0, 0, 0};
`else
        ord = '{0, 1, 2, 3, 0};
        pk  = '{0, 0, 0, 0, 1};
`endif
        do_reset();
        for (int n = 0; n < 4; n++) begin
            push(n, 32'(n << 8), 1'b0);
            push(n, 32'(n << 8) | 32'h1, 1'b1);
        end
        push(0, 32'h010, 1'b0);
        push(0, 32'h011, 1'b1);
        drive();
        run_until(10, 40);
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 2; b++) begin
                e = 32'((ord[p] << 8) | (pk[p] << 4) | b);
                total++;
                if (log_d[2*p+b] !== e ||
                    log_g[2*p+b] !== 4'(1 << ord[p])) begin
                    bad++;
                    $display("FAIL order_p%0d_b%0d got d=%h g=%b exp d=%h",
                             p, b, log_d[2*p+b], log_g[2*p+b], e);
                end
            end
        end
        total++;
        if (hot_err !== 0) begin
            bad++;
            $display("FAIL grant_onehot got=%0d exp=0", hot_err);
        end
        total++;
        if (log_c[2] - log_c[1] !== 2) begin
            bad++;
            $display("FAIL bubble got=%0d exp=2", log_c[2] - log_c[1]);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int b = 0; b < 4; b++)
            push(2, 32'h200 + 32'(b), b == 3);
        drive();
        run_until(2, 10);
        m_tready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            total++;
            if (snap_md !== 32'h202 || snap_sr !== 4'b0000 ||
                snap_mv !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold%0d got d=%h r=%b v=%b exp 202",
                         k, snap_md, snap_sr, snap_mv);
            end
        end
        m_tready = 1'b1;
        run_until(4, 10);
        repeat (3) step();
        total++;
        if (log_n !== 4) begin
            bad++;
            $display("FAIL bp_count got=%0d exp=4", log_n);
        end
        for (int b = 0; b < 4; b++) begin
            total++;
            if (log_d[b] !== 32'h200 + 32'(b)) begin
                bad++;
                $display("FAIL bp_beat%0d got=%h exp=%h",
                         b, log_d[b], 32'h200 + 32'(b));
            end
        end
        total++;
        if (log_c[2] - log_c[1] !== 6) begin
            bad++;
            $display("FAIL bp_gap got=%0d exp=6", log_c[2] - log_c[1]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int b = 0; b < 4; b++)
            push(3, 32'h300 + 32'(b), b == 3);
        drive();
        run_until(2, 10);
        resetn = 1'b0;
        #1;
        total++;
        if (m_tvalid !== 1'b0 || m_grant !== 4'b0000 ||
            s_tready !== 4'b0000) begin
            bad++;
            $display("FAIL rmid_abort got v=%b g=%b r=%b exp 0",
                     m_tvalid, m_grant, s_tready);
        end
        do_reset();
        push(3, 32'h310, 1'b1);
        push(0, 32'h010, 1'b1);
        drive();
        run_until(2, 15);
        total++;
        if (log_g[0] !== 4'b0001 || log_d[0] !== 32'h010) begin
            bad++;
            $display("FAIL rmid_first got g=%b d=%h exp 0001 010",
                     log_g[0], log_d[0]);
        end
        total++;
        if (log_g[1] !== 4'b1000 || log_d[1] !== 32'h310) begin
            bad++;
            $display("FAIL rmid_second got g=%b d=%h exp 1000 310",
                     log_g[1], log_d[1]);
        end
    endtask

    task automatic test_stall();
        logic [31:0] e [4];
        e = '{32'h000, 32'h001, 32'h002, 32'h100};
        do_reset();
        push(0, 32'h000, 1'b0);
        push(0, 32'h001, 1'b0);
        push(0, 32'h002, 1'b1);
        drive();
        run_until(1, 10);
        stall[0] = 1'b1;
        push(1, 32'h100, 1'b1);
        drive();
        for (int k = 0; k < 10; k++) begin
            step();
            total++;
            if (snap_g !== 4'b0001 || snap_mv !== 1'b0 ||
                snap_sr[1] !== 1'b0) begin
                bad++;
                $display("FAIL stall_hold%0d got g=%b v=%b r=%b",
                         k, snap_g, snap_mv, snap_sr);
            end
        end
        stall[0] = 1'b0;
        drive();
        run_until(4, 15);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (log_d[i] !== e[i]) begin
                bad++;
                $display("FAIL stall_beat%0d got=%h exp=%h",
                         i, log_d[i], e[i]);
            end
        end
        total++;
        if (log_g[3] !== 4'b0010) begin
            bad++;
            $display("FAIL stall_next got=%b exp=0010", log_g[3]);
        end
    endtask

    initial begin
        resetn   = 1'b0;
        m_tready = 1'b1;
        stall    = 4'b0000;
        hs       = 4'b0000;
        log_n    = 0;
        for (int n = 0; n < 4; n++) begin
            hd[n] = 0;
            tl[n] = 0;
        end
        drive();
        test_reset();
        test_single();
        test_all_req();
        test_backpressure();
        test_reset_mid();
        test_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
